// File: rtl/m_unit_pipelined_if.sv
// Issue/writeback port bundle of the M-extension execute unit.
//
// Handshake: an operation transfers on a rising clk edge where in_valid and
// in_ready are both high (and the unit is not being flushed). The master holds
// funct3/rs1/rs2/rd stable while in_valid is high and in_ready is low. in_ready
// may depend on funct3 (divides additionally wait for the multiplier to
// drain). out_valid is a single-cycle pulse per completed operation with no
// back-pressure; result/result_dest hold their last value while out_valid is low.
interface m_unit_pipelined_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [TAG_W-1:0] rd;
    logic             out_valid;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] result_dest;

    modport master (
        output in_valid, funct3, rs1, rs2, rd,
        input  in_ready, out_valid, result, result_dest
    );

    modport slave (
        input  in_valid, funct3, rs1, rs2, rd,
        output in_ready, out_valid, result, result_dest
    );
endinterface

// File: rtl/m_unit_pipelined.sv
// RV32M/RV64M execute unit: pipelined multiplier (one op per cycle, latency
// MUL_STAGES) beside an iterative restoring divider (DIV_UNROLL bits/cycle).
// Results leave through one registered writeback port tagged with rd.
module m_unit_pipelined #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int DIV_UNROLL = 1,
    parameter int TAG_W      = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    m_unit_pipelined_if.slave io,
    output logic              busy,
    output logic [1:0]        dbg_div_state_o
);
    localparam int PW    = 2 * XLEN + 2;
    localparam int N     = XLEN / DIV_UNROLL;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N - 1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } div_state_e;

    div_state_e div_state_q, div_state_d;

    // ---------------- issue control ----------------
    logic op_is_div, op_is_rem, accept, mul_acc, div_acc, mul_any_v;

    assign op_is_div = io.funct3[2];
    assign op_is_rem = io.funct3[1];
    // Divides wait for an empty multiplier so both result streams never meet.
    assign io.in_ready = (div_state_q == S_IDLE) && (!op_is_div || !mul_any_v);
    assign accept      = io.in_valid && io.in_ready && !flush;
    assign mul_acc     = accept && !op_is_div;
    assign div_acc     = accept && op_is_div;

    // ---------------- multiplier ----------------
    logic                    a_sext, b_sext, mul_hi;
    logic signed [XLEN:0]    mul_a, mul_b;
    logic signed [PW-1:0]    prod_c;
    logic [2*XLEN-1:0]       prod_keep;
    logic                    unused_prod_top;

    // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
    assign a_sext    = (io.funct3[1:0] == 2'b01) || (io.funct3[1:0] == 2'b10);
    assign b_sext    = (io.funct3[1:0] == 2'b01);
    assign mul_a     = {a_sext & io.rs1[XLEN-1], io.rs1};
    assign mul_b     = {b_sext & io.rs2[XLEN-1], io.rs2};
    assign prod_c    = PW'(mul_a) * PW'(mul_b);
    assign prod_keep = prod_c[2*XLEN-1:0];
    assign unused_prod_top = ^prod_c[PW-1:2*XLEN];
    assign mul_hi    = (io.funct3[1:0] != 2'b00);

    logic                    mul_fin_v, mul_fin_hi;
    logic [TAG_W-1:0]        mul_fin_tag;
    logic [2*XLEN-1:0]       mul_fin_prod;
    logic [XLEN-1:0]         mul_res;

    // The output register is the last multiplier stage, so MUL_STAGES-1
    // internal stages sit between the operands and the writeback register.
    if (MUL_STAGES == 1) begin : g_mul_comb
        assign mul_fin_v    = mul_acc;
        assign mul_fin_hi   = mul_hi;
        assign mul_fin_tag  = io.rd;
        assign mul_fin_prod = prod_keep;
        assign mul_any_v    = 1'b0;
    end else begin : g_mul_pipe
        localparam int D = MUL_STAGES - 1;
        logic [D-1:0]       v_q, hi_q;
        logic [TAG_W-1:0]   tag_q  [D];
        logic [2*XLEN-1:0]  prod_q [D];

        // Valid/tag/op shift register alongside the product data.
        always_ff @(posedge clk or posedge resetn) begin
            if (resetn) begin
                v_q  <= '0;
                hi_q <= '0;
                for (int i = 0; i < D; i++) begin
                    tag_q[i]  <= '0;
                    prod_q[i] <= '0;
                end
            end else begin
                v_q[0]    <= mul_acc;
                hi_q[0]   <= mul_hi;
                tag_q[0]  <= io.rd;
                prod_q[0] <= prod_keep;
                for (int i = 1; i < D; i++) begin
                    v_q[i]    <= v_q[i-1];
                    hi_q[i]   <= hi_q[i-1];
                    tag_q[i]  <= tag_q[i-1];
                    prod_q[i] <= prod_q[i-1];
                end
                if (flush) begin
                    v_q <= '0;
                end
            end
        end

        assign mul_fin_v    = v_q[D-1];
        assign mul_fin_hi   = hi_q[D-1];
        assign mul_fin_tag  = tag_q[D-1];
        assign mul_fin_prod = prod_q[D-1];
        assign mul_any_v    = |v_q;
    end

    assign mul_res = mul_fin_hi ? mul_fin_prod[2*XLEN-1:XLEN] : mul_fin_prod[XLEN-1:0];

    // ---------------- divider operand preparation ----------------
    logic            div_sgn, a_neg, b_neg, div_zero, div_ovf, div_special;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    assign div_sgn     = !io.funct3[0];
    assign a_neg       = div_sgn && io.rs1[XLEN-1];
    assign b_neg       = div_sgn && io.rs2[XLEN-1];
    assign a_mag       = a_neg ? -io.rs1 : io.rs1;
    assign b_mag       = b_neg ? -io.rs2 : io.rs2;
    assign div_zero    = (io.rs2 == '0);
    assign div_ovf     = div_sgn && (io.rs1 == MOST_NEG) && (io.rs2 == '1);
    assign div_special = div_zero || div_ovf;
    assign special_res = div_zero ? (op_is_rem ? io.rs1 : '1)
                                  : (op_is_rem ? '0 : io.rs1);

    // ---------------- divider datapath ----------------
    logic [XLEN-1:0]  quo_q, rem_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_neg_q, r_neg_q, is_rem_q;
    logic [TAG_W-1:0] div_tag_q;
    logic [XLEN-1:0]  step_q, step_r, q_fix, r_fix, div_res;
    logic [XLEN:0]    step_sh;
    logic             div_last;

    // DIV_UNROLL restoring shift-subtract steps: the dividend shifts out of the
    // quotient register into the partial remainder as quotient bits shift in.
    always_comb begin
        step_q  = quo_q;
        step_r  = rem_q;
        step_sh = '0;
        for (int k = 0; k < DIV_UNROLL; k++) begin
            step_sh = {step_r, step_q[XLEN-1]};
            step_q  = {step_q[XLEN-2:0], 1'b0};
            if (step_sh >= {1'b0, dvs_q}) begin
                step_sh   = step_sh - {1'b0, dvs_q};
                step_q[0] = 1'b1;
            end
            step_r = step_sh[XLEN-1:0];
        end
    end

    assign q_fix    = q_neg_q ? -step_q : step_q;
    assign r_fix    = r_neg_q ? -step_r : step_r;
    assign div_res  = is_rem_q ? r_fix : q_fix;
    assign div_last = (div_state_q == S_ITER) && (cnt_q == '0) && !flush;

    // Divider FSM state register.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            div_state_q <= S_IDLE;
        end else begin
            div_state_q <= div_state_d;
        end
    end

    // Divider next state: specials skip ITER; flush always returns to IDLE.
    always_comb begin
        div_state_d = div_state_q;
        case (div_state_q)
            S_IDLE: if (div_acc) div_state_d = div_special ? S_FIX : S_ITER;
            S_ITER: if (cnt_q == '0) div_state_d = S_FIX;
            S_FIX:  div_state_d = S_IDLE;
            default: div_state_d = S_IDLE;
        endcase
        if (flush) begin
            div_state_d = S_IDLE;
        end
    end

    // Divider operands, iteration counter and latched result signs.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            is_rem_q  <= 1'b0;
            div_tag_q <= '0;
        end else if (div_acc) begin
            quo_q     <= a_mag;
            rem_q     <= '0;
            dvs_q     <= b_mag;
            cnt_q     <= CNT_INIT;
            q_neg_q   <= a_neg ^ b_neg;
            r_neg_q   <= a_neg;
            is_rem_q  <= op_is_rem;
            div_tag_q <= io.rd;
        end else if (div_state_q == S_ITER) begin
            quo_q <= step_q;
            rem_q <= step_r;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // ---------------- writeback register ----------------
    logic             out_valid_q;
    logic [XLEN-1:0]  result_q;
    logic [TAG_W-1:0] result_dest_q;

    // Registered writeback; the divider result is loaded on entry to FIX so it
    // is presented during FIX. A flush suppresses whatever would complete.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            out_valid_q   <= 1'b0;
            result_q      <= '0;
            result_dest_q <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (!flush) begin
                if (mul_fin_v) begin
                    out_valid_q   <= 1'b1;
                    result_q      <= mul_res;
                    result_dest_q <= mul_fin_tag;
                end else if (div_acc && div_special) begin
                    out_valid_q   <= 1'b1;
                    result_q      <= special_res;
                    result_dest_q <= io.rd;
                end else if (div_last) begin
                    out_valid_q   <= 1'b1;
                    result_q      <= div_res;
                    result_dest_q <= div_tag_q;
                end
            end
        end
    end

    assign io.out_valid     = out_valid_q;
    assign io.result        = result_q;
    assign io.result_dest   = result_dest_q;
    assign busy             = mul_any_v || (div_state_q != S_IDLE);
    assign dbg_div_state_o  = div_state_q;
endmodule

// File: tb/tb_m_unit_pipelined.sv
// Bench for m_unit_pipelined: a default 32-bit instance and a 64-bit instance
// (MUL_STAGES=4, DIV_UNROLL=4) driven with directed vectors; expected results
// and their due cycles go into queues checked by per-instance monitors.
`timescale 1ns/1ps
module tb_m_unit_pipelined;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       flush, flush64;
    logic       busy, busy64;
    logic [1:0] st32, st64;

    m_unit_pipelined_if #(.XLEN(32), .TAG_W(5)) io32 ();
    m_unit_pipelined_if #(.XLEN(64), .TAG_W(5)) io64 ();

    m_unit_pipelined dut (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush),
        .io              (io32),
        .busy            (busy),
        .dbg_div_state_o (st32)
    );

    m_unit_pipelined #(.XLEN(64), .MUL_STAGES(4), .DIV_UNROLL(4), .TAG_W(5)) dut64 (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush64),
        .io              (io64),
        .busy            (busy64),
        .dbg_div_state_o (st64)
    );

    int cyc = 0;
    int total = 0;
    int bad = 0;
    // {due cycle[31:0], tag[4:0], data[63:0]}
    logic [100:0] exp_q[$];
    logic [100:0] exp64_q[$];
    logic [100:0] e32, e64;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (resetn === 1'b0 && io32.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon32_unexpected: got result %h dest %0d expected no output",
                         io32.result, io32.result_dest);
            end else begin
                e32 = exp_q.pop_front();
                chk("mon32_data", 64'(io32.result), e32[63:0]);
                chk("mon32_dest", 64'(io32.result_dest), 64'(e32[68:64]));
                chk("mon32_cycle", 64'(cyc), 64'(e32[100:69]));
            end
        end
    end

    // Monitor for the 64-bit instance.
    always @(negedge clk) begin
        if (resetn === 1'b0 && io64.out_valid === 1'b1) begin
            if (exp64_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon64_unexpected: got result %h dest %0d expected no output",
                         io64.result, io64.result_dest);
            end else begin
                e64 = exp64_q.pop_front();
                chk("mon64_data", io64.result, e64[63:0]);
                chk("mon64_dest", 64'(io64.result_dest), 64'(e64[68:64]));
                chk("mon64_cycle", 64'(cyc), 64'(e64[100:69]));
            end
        end
    end

    // Offer one op, wait (bounded) for acceptance, queue the expected result
    // due lat cycles after the accept cycle (lat=0: op is expected to be killed).
    task automatic issue(input bit wide, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag,
                         input logic [63:0] exp, input int lat, output int t);
        int n = 0;
        t = -1;
        if (wide) begin
            io64.in_valid = 1'b1; io64.funct3 = f3; io64.rs1 = a; io64.rs2 = b; io64.rd = tag;
        end else begin
            io32.in_valid = 1'b1; io32.funct3 = f3; io32.rs1 = a[31:0]; io32.rs2 = b[31:0]; io32.rd = tag;
        end
        while (t < 0 && n < 200) begin
            @(negedge clk);
            if (wide ? io64.in_ready : io32.in_ready) t = cyc;
            n++;
        end
        if (t < 0) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got no in_ready in 200 cycles expected acceptance (tag %0d)", tag);
        end else if (lat > 0) begin
            if (wide) exp64_q.push_back({32'(t + lat), tag, exp});
            else      exp_q.push_back({32'(t + lat), tag, exp});
        end
        @(posedge clk);
        #1;
        io32.in_valid = 1'b0;
        io64.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || exp64_q.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0", exp_q.size(), exp64_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, td, tm;
        resetn = 1'b1;
        flush = 1'b0;
        flush64 = 1'b0;
        io32.in_valid = 1'b0; io32.funct3 = 3'b000; io32.rs1 = '0; io32.rs2 = '0; io32.rd = '0;
        io64.in_valid = 1'b0; io64.funct3 = 3'b000; io64.rs1 = '0; io64.rs2 = '0; io64.rd = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(io32.in_ready), 64'd1);
        chk("rst_out_valid", 64'(io32.out_valid), 64'd0);
        chk("rst_result", 64'(io32.result), 64'd0);
        chk("rst_dest", 64'(io32.result_dest), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_state", 64'(st32), 64'd0);
        chk("rst64_in_ready", 64'(io64.in_ready), 64'd1);
        chk("rst64_busy", 64'(busy64), 64'd0);
        @(posedge clk);
        #1;

        // Back-to-back multiplies, issue order and tags preserved.
        issue(0, 3'b000, 64'h7, 64'hFFFF_FFFD, 5'd1, 64'hFFFF_FFEB, 2, t1);
        issue(0, 3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd2, 64'hFFFF_FFFE, 2, t2);
        chk("mul_back_to_back", 64'(t2), 64'(t1 + 1));
        issue(0, 3'b001, 64'h8000_0000, 64'h8000_0000, 5'd3, 64'h4000_0000, 2, t1);
        issue(0, 3'b010, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd4, 64'hFFFF_FFFF, 2, t1);

        // Signed divide; a multiply offered meanwhile waits until after FIX.
        issue(0, 3'b100, 64'hFFFF_FFF9, 64'h2, 5'd5, 64'hFFFF_FFFD, 33, td);
        @(negedge clk);
        chk("div_in_ready_low", 64'(io32.in_ready), 64'd0);
        chk("div_busy", 64'(busy), 64'd1);
        chk("div_state_iter", 64'(st32), 64'd1);
        issue(0, 3'b000, 64'h3, 64'h5, 5'd6, 64'd15, 2, tm);
        chk("mul_after_fix", 64'(tm), 64'(td + 34));
        issue(0, 3'b110, 64'hFFFF_FFF9, 64'h2, 5'd7, 64'hFFFF_FFFF, 33, t1);
        issue(0, 3'b101, 64'd100, 64'd7, 5'd8, 64'd14, 33, t1);
        issue(0, 3'b111, 64'd100, 64'd7, 5'd9, 64'd2, 33, t1);

        // Special cases complete the cycle after acceptance.
        issue(0, 3'b100, 64'd9, 64'd0, 5'd10, 64'hFFFF_FFFF, 1, t1);
        issue(0, 3'b110, 64'd5, 64'd0, 5'd11, 64'd5, 1, t1);
        issue(0, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 5'd12, 64'h8000_0000, 1, t1);
        issue(0, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 5'd13, 64'd0, 1, t1);
        drain();

        // Flush a divide ten cycles in.
        issue(0, 3'b100, 64'd50, 64'd3, 5'd14, 64'd0, 0, t1);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_div_busy", 64'(busy), 64'd0);
        chk("flush_div_in_ready", 64'(io32.in_ready), 64'd1);

        // Flush a multiply sitting in stage 1 (it would complete this cycle).
        @(posedge clk);
        #1;
        issue(0, 3'b000, 64'd4, 64'd4, 5'd15, 64'd0, 0, t1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_mul_busy", 64'(busy), 64'd0);
        chk("flush_mul_in_ready", 64'(io32.in_ready), 64'd1);
        repeat (40) @(posedge clk);
        #1;
        issue(0, 3'b000, 64'd6, 64'd7, 5'd17, 64'd42, 2, t1);

        // 64-bit instance: unroll-by-4 divider and four-stage multiplier.
        issue(1, 3'b101, 64'h8000_0000_0000_0000, 64'd3, 5'd20, 64'h2AAA_AAAA_AAAA_AAAA, 17, t1);
        issue(1, 3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd21, 64'hFFFF_FFFF_FFFF_FFEB, 4, t1);
        issue(1, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd22,
              64'hFFFF_FFFF_FFFF_FFFE, 4, t2);
        chk("mul64_back_to_back", 64'(t2), 64'(t1 + 1));
        issue(1, 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd23, 64'hFFFF_FFFF_FFFF_FFFD, 17, t1);
        drain();

        // Asynchronous reset in the middle of a divide.
        issue(0, 3'b101, 64'd1000, 64'd7, 5'd16, 64'd0, 0, t1);
        repeat (5) @(posedge clk);
        #2;
        resetn = 1'b1;
        #1;
        chk("amid_rst_busy", 64'(busy), 64'd0);
        chk("amid_rst_out_valid", 64'(io32.out_valid), 64'd0);
        chk("amid_rst_result", 64'(io32.result), 64'd0);
        chk("amid_rst_dest", 64'(io32.result_dest), 64'd0);
        chk("amid_rst_state", 64'(st32), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        chk("queue32_empty", 64'(exp_q.size()), 64'd0);
        chk("queue64_empty", 64'(exp64_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/m_unit_pipelined.md
# m_unit_pipelined

Parametrised RV32M/RV64M execute unit: the successor of the current single-op M unit. It sits in the EX stage beside the integer ALU and takes decoded M-extension operations with a valid/ready handshake. Multiplies run through a fully pipelined multiplier that accepts one operation per cycle. Divides and remainders run on an iterative divider that retires `DIV_UNROLL` quotient bits per cycle. Results return to writeback with their destination tag.

## Interface
- `XLEN`, 32: operand/result width; 32 or 64.
- `MUL_STAGES`, 2: multiplier pipeline depth; 1..4.
- `DIV_UNROLL`, 1: quotient bits per divider cycle; 1, 2 or 4; must divide `XLEN`.
- `TAG_W`, 5: destination tag width.

- `clk`  in  1  clock.
- `resetn`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  kill all in-flight operations (pipeline redirect).
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  unit can accept this cycle.
- `funct3`  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`, `rs2`  in  XLEN  operands.
- `rd`  in  TAG_W  destination tag.
- `out_valid`  out  1  result valid, one-cycle pulse per op.
- `result`  out  XLEN  result data.
- `result_dest`  out  TAG_W  tag of the op producing `result`.
- `busy`  out  1  any operation in flight.

## Operation
- Accept = `in_valid && in_ready && !flush`.
- Multiplier:
  - Operands extended to XLEN+1 bits: signed for MULH and for rs1 of MULHSU, zero-extended otherwise.
  - Product is 2·XLEN+2 bits. MUL returns the low XLEN bits; MULH* return bits [2·XLEN-1:XLEN].
  - A valid/tag/op shift register of depth `MUL_STAGES` runs alongside the data pipeline.
- Divider FSM states: IDLE, ITER, FIX.
  - IDLE→ITER on accepting a DIV* or REM* op. Operands are converted to magnitudes (signed ops), and the result signs are latched.
  - ITER runs N = XLEN/DIV_UNROLL cycles, doing `DIV_UNROLL` restoring shift-subtract steps per cycle. An iteration counter counts down from N-1 to 0.
  - FIX: applies the latched signs (quotient negated if operand signs differ; remainder takes the sign of rs1), drives the output, then returns to IDLE.
  - Special cases bypass ITER and go straight IDLE→FIX:
    - Divisor 0: quotient all-ones, remainder = rs1.
    - Signed most-negative ÷ -1: quotient = rs1, remainder 0.
- `in_ready`:
  - Mul ops: high when the divider is IDLE.
  - Div ops: high when the divider is IDLE and the mul pipeline holds no valid entry.
  - Deasserted in any non-IDLE divider state.
  - Mul and div results therefore never collide.
- `flush` clears every mul-stage valid bit and returns the divider to IDLE. No `out_valid` is produced for killed ops, including an op completing in the flush cycle.
- `busy` = any mul stage valid, or divider not IDLE.

## Timing
- Reset: `in_ready`=1, `out_valid`=0, `result`=0, `result_dest`=0, `busy`=0, divider IDLE, all stage valids 0.
- Mul: accepted at cycle t, `out_valid` at t+`MUL_STAGES`. Throughput is 1 per cycle; back-to-back results keep issue order.
- Div: accepted at t; ITER covers t+1..t+N; `out_valid` at t+N+1. For XLEN=32, DIV_UNROLL=1, that is t+33.
- Div special case: `out_valid` at t+1.
- `in_ready` for the next div returns in the cycle after FIX. A new op may be accepted in that same cycle.
- Outputs are registered. `result` and `result_dest` hold their last values when `out_valid`=0.
- Reset asserted mid-operation clears all state asynchronously; no result emerges after release.

## Test plan
- MUL 7×-3, then MULHU 0xFFFFFFFF×0xFFFFFFFF on consecutive cycles → 0xFFFFFFEB at t+2 and 0xFFFFFFFE at t+3, tags preserved.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → -3 (0xFFFFFFFD) at t+33; REM -7/2 → -1; DIVU 100/7 → 14; REMU → 2. During the divide, `in_ready`=0, and a MUL offered then is stalled until accepted in the cycle after FIX.
- DIV x/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/-1 → 0x80000000; REM of the same → 0. All at t+1.
- Flush at t+10 of a DIV and together with a mul in stage 1 → no `out_valid`, `busy`=0 and `in_ready`=1 next cycle.
- Reparameterise XLEN=64, DIV_UNROLL=4, MUL_STAGES=4 → DIVU 2^63/3 gives 0x2AAAAAAAAAAAAAAA at t+17; MUL latency 4.
